alu_datapath: RTL and testbench

ALU_DATAPATH -- requirements
Module: alu_datapath

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_core.sv | 71 +++++++
 rtl/alu_datapath.sv | 93 +++++++++
 tb/tb_alu_datapath.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath slice: default widths, op-code
// constants and operand-select encodings.
// Optional feature macro: ALU_SHIFT_EN (enables SHL/SHR/ASR in alu_core).
package alu_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_PC_WIDTH = 30;

  // ALU op codes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ASR  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_MVN  = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_RSV  = 4'hB;
  localparam logic [3:0] OP_SLT  = 4'hC;
  localparam logic [3:0] OP_SLTU = 4'hD;
  localparam logic [3:0] OP_SEQ  = 4'hE;
  localparam logic [3:0] OP_SC   = 4'hF;

  // A-operand select
  localparam logic A_SEL_REG = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;

  // B-operand select
  localparam logic [1:0] B_SEL_REG   = 2'd0;
  localparam logic [1:0] B_SEL_IMM16 = 2'd1;
  localparam logic [1:0] B_SEL_IMM24 = 2'd2;
  localparam logic [1:0] B_SEL_ZERO  = 2'd3;

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational ALU: res = f(op, a, b).
// Ports:
//   op  [3:0]       operation code (see alu_pkg OP_*)
//   a   [WIDTH-1:0] operand A
//   b   [WIDTH-1:0] operand B
//   res [WIDTH-1:0] result; compare/carry ops return a zero-extended bit
// Macro ALU_SHIFT_EN: when defined, ops 5/6/7 are barrel shifts by b[4:0];
// otherwise those ops return 0 and no shifter is built.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  // One extra bit so the carry-out of a+b is available for OP_SC.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;
  logic             eq;

  assign sum_ext     = {1'b0, a} + {1'b0, b};
  assign diff        = a - b;
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;
  assign eq          = (a == b);

`ifdef ALU_SHIFT_EN
  logic [4:0]       shamt;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] shr_res;
  logic [WIDTH-1:0] asr_res;

  assign shamt   = b[4:0];
  assign shl_res = a << shamt;
  assign shr_res = a >> shamt;
  assign asr_res = $unsigned($signed(a) >>> shamt);
`endif

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = sum_ext[WIDTH-1:0];
      OP_SUB:  res = diff;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
`ifdef ALU_SHIFT_EN
      OP_SHL:  res = shl_res;
      OP_SHR:  res = shr_res;
      OP_ASR:  res = asr_res;
`endif
      OP_MOV:  res = b;
      OP_MVN:  res = ~b;
      OP_LUI:  res = b << 16;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SEQ:  res = {{(WIDTH-1){1'b0}}, eq};
      OP_SC:   res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
      // OP_RSV, disabled shifts and any X op fall through to zero
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath
// Operand selection in front of alu_core plus a one-cycle output register.
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset (clears res, cr, out_valid)
//   in_valid   operands/op valid this cycle
//   op [3:0]   ALU operation
//   a_sel      0 = reg_a, 1 = zero-extended pc
//   b_sel [1:0] 0 = reg_b, 1 = zero-extended imm16, 2 = sign-extended imm24, 3 = zero
//   reg_a, reg_b [WIDTH-1:0]  register operands
//   pc [PC_WIDTH-1:0]         current word PC
//   imm16, imm24              immediates
//   res [WIDTH-1:0]  registered result (held while in_valid is low)
//   cr               registered res[0]
//   out_valid        high the cycle after an accepted in_valid
// Macro ALU_SHIFT_EN: passed through to alu_core to enable the shifter.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [3:0]          op,
  input  logic                a_sel,
  input  logic [1:0]          b_sel,
  input  logic [WIDTH-1:0]    reg_a,
  input  logic [WIDTH-1:0]    reg_b,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         imm16,
  input  logic [23:0]         imm24,
  output logic [WIDTH-1:0]    res,
  output logic                cr,
  output logic                out_valid
);

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] res_next;

  logic [WIDTH-1:0] res_reg;
  logic             cr_reg;
  logic             out_valid_reg;

  always_comb begin
    a_op = reg_a;
    if (a_sel == A_SEL_PC) begin
      a_op = {{(WIDTH-PC_WIDTH){1'b0}}, pc};
    end
  end

  always_comb begin
    b_op = '0;
    case (b_sel)
      B_SEL_REG:   b_op = reg_b;
      B_SEL_IMM16: b_op = {{(WIDTH-16){1'b0}}, imm16};
      // Sign extension makes imm24 usable as a signed branch offset.
      B_SEL_IMM24: b_op = {{(WIDTH-24){imm24[23]}}, imm24};
      B_SEL_ZERO:  b_op = '0;
      default:     b_op = '0;
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .op  (op),
    .a   (a_op),
    .b   (b_op),
    .res (res_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_reg       <= '0;
      cr_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        res_reg <= res_next;
        cr_reg  <= res_next[0];
      end
    end
  end

  assign res       = res_reg;
  assign cr        = cr_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath
// Scoreboard bench for alu_datapath (default widths). Inputs are driven on
// the falling edge; the result of the previous rising edge is checked on the
// same falling edge before new inputs are applied.
// Macro ALU_SHIFT_EN: selects the expected shift results.
module tb_alu_datapath;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  op;
  logic        a_sel;
  logic [1:0]  b_sel;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [29:0] pc;
  logic [15:0] imm16;
  logic [23:0] imm24;
  logic [31:0] res;
  logic        cr;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  bit          pend_valid = 1'b0;
  logic [31:0] last_res   = '0;

  alu_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .pc        (pc),
    .imm16     (imm16),
    .imm24     (imm24),
    .res       (res),
    .cr        (cr),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model, written independently of the RTL structure.
  function automatic logic [31:0] model(input logic [3:0] o, input bit as, input logic [1:0] bs,
                                        input logic [31:0] ra, input logic [31:0] rb,
                                        input logic [29:0] p, input logic [15:0] i16,
                                        input logic [23:0] i24);
    logic [31:0] a, b, r;
    logic [32:0] w;
    int sh;
    a = as ? {2'b00, p} : ra;
    case (bs)
      2'd0:    b = rb;
      2'd1:    b = {16'h0000, i16};
      2'd2:    b = 32'($signed(i24));
      default: b = 32'h0;
    endcase
    sh = int'(b[4:0]);
    r  = 32'h0;
    case (o)
      4'h0: r = a + b;
      4'h1: r = a + ~b + 32'd1;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
`ifdef ALU_SHIFT_EN
      4'h5: begin r = a; for (int k = 0; k < sh; k++) r = {r[30:0], 1'b0}; end
      4'h6: begin r = a; for (int k = 0; k < sh; k++) r = {1'b0, r[31:1]}; end
      4'h7: begin r = a; for (int k = 0; k < sh; k++) r = {r[31], r[31:1]}; end
`endif
      4'h8: r = b;
      4'h9: r = ~b;
      4'hA: r = {b[15:0], 16'h0000};
      4'hC: r = {31'd0, (a[31] != b[31]) ? a[31] : (a < b)};
      4'hD: begin w = {1'b0, a} - {1'b0, b}; r = {31'd0, w[32]}; end
      4'hE: r = {31'd0, a == b};
      4'hF: begin w = {1'b0, a} + {1'b0, b}; r = {31'd0, w[32]}; end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Check what the last rising edge produced.
  task automatic check_outputs();
    logic [31:0] e;
    string t;
    if (pend_valid) begin
      check_eq("out_valid", {31'd0, out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("txn %s: res=%h cr=%b exp=%h", t, res, cr, e);
        check_eq({t, "_res"}, res, e);
        check_eq({t, "_cr"}, {31'd0, cr}, {31'd0, e[0]});
        last_res = e;
      end
    end else begin
      $display("txn idle: res=%h out_valid=%b", res, out_valid);
      check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("idle_hold_res", res, last_res);
    end
  endtask

  task automatic drive(input string tag, input bit v, input logic [3:0] o, input bit as,
                       input logic [1:0] bs, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [29:0] p, input logic [15:0] i16, input logic [23:0] i24,
                       input logic [31:0] e);
    @(negedge clk);
    check_outputs();
    in_valid = v;
    op       = o;
    a_sel    = as;
    b_sel    = bs;
    reg_a    = ra;
    reg_b    = rb;
    pc       = p;
    imm16    = i16;
    imm24    = i24;
    if (v) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    pend_valid = v;
  endtask

  task automatic rr(input string tag, input logic [3:0] o, input logic [31:0] ra,
                    input logic [31:0] rb, input logic [31:0] e);
    drive(tag, 1'b1, o, 1'b0, 2'd0, ra, rb, 30'h0, 16'h0, 24'h0, e);
  endtask

  task automatic idle();
    drive("idle", 1'b0, 4'h0, 1'b0, 2'd0, 32'h0, 32'h0, 30'h0, 16'h0, 24'h0, 32'h0);
  endtask

  logic [31:0] shr_exp, asr_exp;
  bit          rv, ras;
  logic [3:0]  ro;
  logic [1:0]  rbs;
  logic [31:0] rra, rrb;
  logic [29:0] rp;
  logic [15:0] ri16;
  logic [23:0] ri24;

  initial begin
`ifdef ALU_SHIFT_EN
    shr_exp = 32'h0800_0000;
    asr_exp = 32'hF800_0000;
`else
    shr_exp = 32'h0;
    asr_exp = 32'h0;
`endif
    rst = 1'b0; in_valid = 1'b0; op = 4'h0; a_sel = 1'b0; b_sel = 2'd0;
    reg_a = '0; reg_b = '0; pc = '0; imm16 = '0; imm24 = '0;
    #1;
    check_eq("reset_res", res, 32'h0);
    check_eq("reset_cr", {31'd0, cr}, 32'd0);
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    rr("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    rr("sc_carry", 4'hF, 32'hFFFF_FFFF, 32'h1, 32'h1);
    drive("branch", 1'b1, 4'h0, 1'b1, 2'd2, 32'h0, 32'h0, 30'h10, 16'h0, 24'hFFFFFE, 32'h0000_000E);
    drive("imm16_or", 1'b1, 4'h3, 1'b0, 2'd1, 32'h0, 32'h0, 30'h0, 16'h8000, 24'h0, 32'h0000_8000);
    rr("slt", 4'hC, 32'hFFFF_FFFF, 32'h1, 32'h1);
    rr("sltu", 4'hD, 32'hFFFF_FFFF, 32'h1, 32'h0);
    rr("seq_ne", 4'hE, 32'hFFFF_FFFF, 32'h1, 32'h0);
    drive("seq_zero", 1'b1, 4'hE, 1'b0, 2'd3, 32'h0, 32'h1234, 30'h0, 16'h0, 24'h0, 32'h1);
    rr("asr", 4'h7, 32'h8000_0000, 32'h4, asr_exp);
    rr("shr", 4'h6, 32'h8000_0000, 32'h4, shr_exp);
    rr("shl", 4'h5, 32'h8000_0000, 32'h4, 32'h0);
    idle();
    idle();
    rr("sub", 4'h1, 32'h5, 32'h7, 32'hFFFF_FFFE);
    rr("and", 4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    rr("xor", 4'h4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    rr("mov", 4'h8, 32'h1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    rr("mvn", 4'h9, 32'h1, 32'h0000_00FF, 32'hFFFF_FF00);
    drive("lui", 1'b1, 4'hA, 1'b0, 2'd1, 32'h0, 32'h0, 30'h0, 16'hBEEF, 24'h0, 32'hBEEF_0000);
    rr("rsv", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    rr("sc_nocarry", 4'hF, 32'h7FFF_FFFF, 32'h1, 32'h0);

    // Mid-stream reset: the in-flight result and the one already in res are discarded.
    rr("pre_rst_a", 4'h0, 32'h1, 32'h2, 32'h3);
    rr("pre_rst_b", 4'h0, 32'h2, 32'h2, 32'h4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_res", res, 32'h0);
    check_eq("midrst_cr", {31'd0, cr}, 32'd0);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    pend_valid = 1'b0;
    last_res   = 32'h0;
    @(negedge clk);
    check_eq("inrst_res", res, 32'h0);
    check_eq("inrst_out_valid", {31'd0, out_valid}, 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    idle();
    rr("post_rst", 4'h8, 32'h0, 32'h55, 32'h55);

    // Randomised traffic through the model
    for (int i = 0; i < 40; i++) begin
      rv   = ($urandom_range(0, 3) != 0);
      ro   = 4'($urandom_range(0, 15));
      ras  = 1'($urandom_range(0, 1));
      rbs  = 2'($urandom_range(0, 3));
      rra  = $urandom();
      rrb  = (i % 4 == 0) ? rra : $urandom();
      rp   = 30'($urandom());
      ri16 = 16'($urandom());
      ri24 = 24'($urandom());
      drive("rand", rv, ro, ras, rbs, rra, rrb, rp, ri16, ri24,
            model(ro, ras, rbs, rra, rrb, rp, ri16, ri24));
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
